// File: rtl/wbs_mem_ctrl.sv
// Wishbone slave for the KD-tree accelerator: address decode, mode/debug/start control and memory write/read sequencing.
// Optional feature: define WBS_READBACK_EN to make the control registers readable and to allow clearing the sticky error.
module wbs_mem_ctrl #(
    parameter int DATA_WIDTH = 11,
    parameter int NODE_AW    = 6,
    parameter int LEAF_AW    = 9,
    parameter int QUERY_AW   = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    node_wen,
    output logic [NODE_AW-1:0]      node_addr,
    output logic [2*DATA_WIDTH-1:0] node_wdata,
    output logic                    leaf_wen,
    output logic [LEAF_AW-1:0]      leaf_addr,
    output logic [63:0]             leaf_wdata,
    output logic                    query_wen,
    output logic [QUERY_AW-1:0]     query_addr,
    output logic [63:0]             query_wdata,
    output logic                    best_ren,
    output logic [QUERY_AW-1:0]     best_addr,
    input  logic [DATA_WIDTH-1:0]   best_rdata,
    output logic                    mode_o,
    output logic                    debug_o,
    output logic                    fsm_start_o,
    input  logic                    fsm_done_i,
    input  logic                    fsm_busy_i
);

    localparam logic [15:0] REG_CTRL  = 16'h3000;
    localparam logic [15:0] REG_QUERY = 16'h3001;
    localparam logic [15:0] REG_LEAF  = 16'h3002;
    localparam logic [15:0] REG_BEST  = 16'h3003;
    localparam logic [15:0] REG_NODE  = 16'h3004;

    localparam logic [15:0] OFF_MODE  = 16'h0000;
    localparam logic [15:0] OFF_DEBUG = 16'h0004;
    localparam logic [15:0] OFF_DONE  = 16'h0008;
    localparam logic [15:0] OFF_START = 16'h000C;
    localparam logic [15:0] OFF_BUSY  = 16'h0010;

    localparam int IDX_W = (LEAF_AW > QUERY_AW) ? LEAF_AW : QUERY_AW;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

    state_t             state;
    logic [31:0]        dat_reg;
    logic               rd_best;
    logic               err;
    logic               hold_valid;
    logic               hold_leaf;
    logic [IDX_W-1:0]   hold_idx;
    logic [31:0]        hold_data;

    logic [15:0]        region;
    logic [15:0]        offset;
    logic               req;
    logic               valid_region;
    logic               wr_ok;
    logic               is_leaf;
    logic [IDX_W-1:0]   word_idx;
    logic               hold_match;
    logic [31:0]        ctrl_rdata;

    assign region       = wbs_adr_i[31:16];
    assign offset       = wbs_adr_i[15:0];
    assign req          = wbs_cyc_i & wbs_stb_i;
    assign valid_region = region inside {REG_CTRL, REG_QUERY, REG_LEAF, REG_BEST, REG_NODE};
    assign wr_ok        = wbs_we_i && (wbs_sel_i == 4'hF);
    assign is_leaf      = (region == REG_LEAF);
    assign word_idx     = is_leaf ? IDX_W'(wbs_adr_i[LEAF_AW+2:3]) : IDX_W'(wbs_adr_i[QUERY_AW+2:3]);
    assign hold_match   = hold_valid && (hold_idx == word_idx) && (hold_leaf == is_leaf);

    // Best-memory data arrives one cycle after best_ren, i.e. during the ack cycle itself.
    assign wbs_dat_o = rd_best ? {{(32-DATA_WIDTH){1'b0}}, best_rdata} : dat_reg;

    always_comb begin
        // NOTE: default first so every path assigns ctrl_rdata and no latch is inferred.
        ctrl_rdata = '0;
`ifdef WBS_READBACK_EN
        case (offset)
            OFF_MODE:  ctrl_rdata = {31'b0, mode_o};
            OFF_DEBUG: ctrl_rdata = {31'b0, debug_o};
            OFF_DONE:  ctrl_rdata = {30'b0, err, fsm_done_i};
            OFF_BUSY:  ctrl_rdata = {31'b0, fsm_busy_i};
            default:   ctrl_rdata = '0;
        endcase
`endif
    end

`ifndef WBS_READBACK_EN
    logic unused_status;
    assign unused_status = &{1'b0, err, fsm_done_i};
`endif

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wbs_ack_o   <= 1'b0;
            dat_reg     <= '0;
            rd_best     <= 1'b0;
            node_wen    <= 1'b0;
            node_addr   <= '0;
            node_wdata  <= '0;
            leaf_wen    <= 1'b0;
            leaf_addr   <= '0;
            leaf_wdata  <= '0;
            query_wen   <= 1'b0;
            query_addr  <= '0;
            query_wdata <= '0;
            best_ren    <= 1'b0;
            best_addr   <= '0;
            mode_o      <= 1'b0;
            debug_o     <= 1'b0;
            fsm_start_o <= 1'b0;
            err         <= 1'b0;
            // NOTE: the hold register is a handful of flops, not a RAM, so resetting it is cheap and keeps it clean.
            hold_valid  <= 1'b0;
            hold_leaf   <= 1'b0;
            hold_idx    <= '0;
            hold_data   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req && valid_region) begin
                        if (region == REG_BEST && !wbs_we_i) begin
                            best_ren  <= 1'b1;
                            best_addr <= wbs_adr_i[QUERY_AW+1:2];
                            state     <= S_RD;
                        end else begin
                            wbs_ack_o <= 1'b1;
                            state     <= S_ACK;
                            if (!wbs_we_i && region == REG_CTRL)
                                dat_reg <= ctrl_rdata;
                            if (wr_ok) begin
                                case (region)
                                    REG_CTRL: begin
                                        case (offset)
                                            OFF_MODE:  mode_o  <= wbs_dat_i[0];
                                            OFF_DEBUG: debug_o <= wbs_dat_i[0];
                                            OFF_START: if (wbs_dat_i[0] && !fsm_busy_i) fsm_start_o <= 1'b1;
`ifdef WBS_READBACK_EN
                                            OFF_DONE:  if (wbs_dat_i[1]) err <= 1'b0;
`endif
                                            default: ;
                                        endcase
                                    end
                                    REG_NODE: begin
                                        if (mode_o && wbs_adr_i[NODE_AW-1:0] != '0) begin
                                            node_wen   <= 1'b1;
                                            node_addr  <= wbs_adr_i[NODE_AW-1:0];
                                            node_wdata <= wbs_dat_i[2*DATA_WIDTH-1:0];
                                        end
                                    end
                                    REG_LEAF, REG_QUERY: begin
                                        if (mode_o) begin
                                            if (!wbs_adr_i[2]) begin
                                                // A later lower half simply replaces any pending one.
                                                hold_valid <= 1'b1;
                                                hold_leaf  <= is_leaf;
                                                hold_idx   <= word_idx;
                                                hold_data  <= wbs_dat_i;
                                            end else if (hold_match) begin
                                                hold_valid <= 1'b0;
                                                if (is_leaf) begin
                                                    leaf_wen   <= 1'b1;
                                                    leaf_addr  <= word_idx[LEAF_AW-1:0];
                                                    leaf_wdata <= {wbs_dat_i, hold_data};
                                                end else begin
                                                    query_wen   <= 1'b1;
                                                    query_addr  <= word_idx[QUERY_AW-1:0];
                                                    query_wdata <= {wbs_dat_i, hold_data};
                                                end
                                            end else begin
                                                err <= 1'b1;
                                            end
                                        end
                                    end
                                    default: ;
                                endcase
                            end
                        end
                    end
                end
                S_RD: begin
                    best_ren <= 1'b0;
                    // An abandoned read still finishes in the memory but is never acknowledged.
                    if (req) begin
                        wbs_ack_o <= 1'b1;
                        rd_best   <= 1'b1;
                        state     <= S_ACK;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    wbs_ack_o   <= 1'b0;
                    dat_reg     <= '0;
                    rd_best     <= 1'b0;
                    node_wen    <= 1'b0;
                    leaf_wen    <= 1'b0;
                    query_wen   <= 1'b0;
                    fsm_start_o <= 1'b0;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wbs_mem_ctrl.sv
// Directed self-checking bench for wbs_mem_ctrl; expected values are hand-computed constants.
module tb_wbs_mem_ctrl;

`ifdef WBS_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        node_wen, leaf_wen, query_wen, best_ren;
    logic [5:0]  node_addr;
    logic [21:0] node_wdata;
    logic [8:0]  leaf_addr, query_addr, best_addr;
    logic [63:0] leaf_wdata, query_wdata;
    logic [10:0] best_rdata = '0;
    logic        mode, debug, start;
    logic        done = 1'b0, busy = 1'b0;

    logic [10:0] best_mem [512];

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always @(posedge clk) if (best_ren) best_rdata <= best_mem[best_addr];

    wbs_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .node_wen(node_wen), .node_addr(node_addr), .node_wdata(node_wdata),
        .leaf_wen(leaf_wen), .leaf_addr(leaf_addr), .leaf_wdata(leaf_wdata),
        .query_wen(query_wen), .query_addr(query_addr), .query_wdata(query_wdata),
        .best_ren(best_ren), .best_addr(best_addr), .best_rdata(best_rdata),
        .mode_o(mode), .debug_o(debug), .fsm_start_o(start),
        .fsm_done_i(done), .fsm_busy_i(busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [3:0] s);
        @(negedge clk);
        adr = a; wdat = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    endtask

    task automatic release_bus();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write/read with a fixed one-cycle ack; leaves the bus idle in the following IDLE cycle.
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w);
        drive(a, d, w, 4'hF);
        step();
        release_bus();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 512; i++) best_mem[i] = 11'(i ^ 9'h155);
        best_mem[4] = 11'h1A5;
        best_mem[7] = 11'h7FF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {63'b0, ack}, 64'h0);
        check("rst_dat", {32'b0, rdat}, 64'h0);
        check("rst_strobes", {59'b0, node_wen, leaf_wen, query_wen, best_ren, start}, 64'h0);
        check("rst_regs", {62'b0, mode, debug}, 64'h0);
        check("rst_addrs", {37'b0, node_addr, leaf_addr, query_addr, best_addr}, 64'h0);
        check("rst_wdata", leaf_wdata | query_wdata | {42'b0, node_wdata}, 64'h0);
        rst_n = 1'b1;

        // MODE write: ack one cycle after the request, exactly one cycle long
        drive(32'h3000_0000, 32'h1, 1'b1, 4'hF);
        step();
        check("mode_ack", {63'b0, ack}, 64'h1);
        check("mode_set", {63'b0, mode}, 64'h1);
        check("mode_no_wen", {61'b0, node_wen, leaf_wen, query_wen}, 64'h0);
        release_bus();
        step();
        check("mode_ack_drop", {63'b0, ack}, 64'h0);

        // Node write and dropped node address 0
        drive(32'h3004_0005, 32'h0001_B801, 1'b1, 4'hF);
        step();
        check("node_wen", {63'b0, node_wen}, 64'h1);
        check("node_addr", {58'b0, node_addr}, 64'h5);
        check("node_wdata", {42'b0, node_wdata}, 64'h01B801);
        release_bus();
        step();
        check("node_wen_pulse", {62'b0, node_wen, ack}, 64'h0);
        drive(32'h3004_0000, 32'h0000_1234, 1'b1, 4'hF);
        step();
        check("node0_ack_nowen", {62'b0, ack, node_wen}, 64'h2);
        release_bus();
        step();

        // Leaf lower + upper assembly
        drive(32'h3002_0018, 32'hAAAA_5555, 1'b1, 4'hF);
        step();
        check("leaf_lo_ack_nowen", {62'b0, ack, leaf_wen}, 64'h2);
        release_bus();
        step();
        drive(32'h3002_001C, 32'h1234_5678, 1'b1, 4'hF);
        step();
        check("leaf_wen", {62'b0, leaf_wen, query_wen}, 64'h2);
        check("leaf_addr", {55'b0, leaf_addr}, 64'h3);
        check("leaf_wdata", leaf_wdata, 64'h1234_5678_AAAA_5555);
        release_bus();
        step();
        check("leaf_wen_pulse", {63'b0, leaf_wen}, 64'h0);

        // Orphan upper half: ack, no write, sticky error
        drive(32'h3001_0024, 32'hDEAD_BEEF, 1'b1, 4'hF);
        step();
        check("orphan_upper", {62'b0, ack, query_wen}, 64'h2);
        release_bus();
        step();
        drive(32'h3000_0008, 32'h0, 1'b0, 4'hF);
        step();
        check("done_err_read", {32'b0, rdat}, RB ? 64'h2 : 64'h0);
        release_bus();
        step();
        check("dat_zero_after_ack", {32'b0, rdat}, 64'h0);

        // Second lower overwrites hold; mismatched upper dropped, matching upper emits
        xfer(32'h3001_0040, 32'h1111_1111, 1'b1);
        xfer(32'h3001_0040, 32'h2222_2222, 1'b1);
        drive(32'h3001_004C, 32'h4444_4444, 1'b1, 4'hF);
        step();
        check("query_mismatch", {63'b0, query_wen}, 64'h0);
        release_bus();
        step();
        drive(32'h3001_0044, 32'h3333_3333, 1'b1, 4'hF);
        step();
        check("query_wen", {63'b0, query_wen}, 64'h1);
        check("query_addr", {55'b0, query_addr}, 64'h8);
        check("query_wdata", query_wdata, 64'h3333_3333_2222_2222);
        release_bus();
        step();

        // Clear error, readback of DONE/MODE, unlisted offset
        xfer(32'h3000_0008, 32'h2, 1'b1);
        done = 1'b1;
        drive(32'h3000_0008, 32'h0, 1'b0, 4'hF);
        step();
        check("done_after_clear", {32'b0, rdat}, RB ? 64'h1 : 64'h0);
        release_bus();
        step();
        done = 1'b0;
        drive(32'h3000_0000, 32'h0, 1'b0, 4'hF);
        step();
        check("mode_read", {32'b0, rdat}, RB ? 64'h1 : 64'h0);
        release_bus();
        step();
        drive(32'h3000_0020, 32'h0, 1'b0, 4'hF);
        step();
        check("unlisted_read", {31'b0, ack, rdat}, 64'h1_0000_0000);
        release_bus();
        step();

        // Best-memory reads
        drive(32'h3003_0010, 32'h0, 1'b0, 4'hF);
        step();
        check("best_ren", {62'b0, best_ren, ack}, 64'h2);
        check("best_addr", {55'b0, best_addr}, 64'h4);
        step();
        check("best_ack", {62'b0, ack, best_ren}, 64'h2);
        check("best_data", {32'b0, rdat}, 64'h0000_01A5);
        release_bus();
        step();
        check("best_ack_drop", {31'b0, ack, rdat}, 64'h0);
        drive(32'h3003_001C, 32'h0, 1'b0, 4'hF);
        step();
        check("best_addr7", {55'b0, best_addr}, 64'h7);
        step();
        check("best_data7", {32'b0, rdat}, 64'h0000_07FF);
        release_bus();
        step();

        // FSM start: pulse when idle, dropped when busy
        drive(32'h3000_000C, 32'h1, 1'b1, 4'hF);
        step();
        check("start_pulse", {62'b0, ack, start}, 64'h3);
        release_bus();
        step();
        check("start_drop", {63'b0, start}, 64'h0);
        busy = 1'b1;
        drive(32'h3000_000C, 32'h1, 1'b1, 4'hF);
        step();
        check("start_busy", {62'b0, ack, start}, 64'h2);
        release_bus();
        step();
        busy = 1'b0;

        // Partial byte select: no side effect
        drive(32'h3000_0000, 32'h0, 1'b1, 4'h3);
        step();
        check("sel_partial", {62'b0, ack, mode}, 64'h3);
        release_bus();
        step();

        // Held strobe: ack, one idle cycle, ack again
        drive(32'h3000_0004, 32'h1, 1'b1, 4'hF);
        step();
        check("held_ack1", {62'b0, ack, debug}, 64'h3);
        step();
        check("held_gap", {63'b0, ack}, 64'h0);
        step();
        check("held_ack2", {63'b0, ack}, 64'h1);
        release_bus();
        step();

        // Invalid region: never acked
        drive(32'h3005_0000, 32'h1, 1'b1, 4'hF);
        step();
        step();
        check("bad_region", {63'b0, ack}, 64'h0);
        release_bus();
        step();

        // Mode cleared: node write dropped
        xfer(32'h3000_0000, 32'h0, 1'b1);
        drive(32'h3004_0009, 32'h0000_0ABC, 1'b1, 4'hF);
        step();
        check("mode0_node", {62'b0, ack, node_wen}, 64'h2);
        release_bus();
        step();

        // Strobe dropped during RD: no ack
        drive(32'h3003_0010, 32'h0, 1'b0, 4'hF);
        step();
        release_bus();
        step();
        check("rd_abort", {63'b0, ack}, 64'h0);
        step();
        check("rd_abort2", {63'b0, ack}, 64'h0);

        // Reset mid-RD discards the pending half-word
        xfer(32'h3000_0000, 32'h1, 1'b1);
        xfer(32'h3002_0018, 32'hCAFE_F00D, 1'b1);
        drive(32'h3003_0010, 32'h0, 1'b0, 4'hF);
        step();
        rst_n = 1'b0;
        #1;
        check("rst_mid_rd", {61'b0, ack, best_ren, mode}, 64'h0);
        step();
        check("rst_hold_ack", {63'b0, ack}, 64'h0);
        release_bus();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("rst_no_ack", {63'b0, ack}, 64'h0);
        xfer(32'h3000_0000, 32'h1, 1'b1);
        drive(32'h3002_001C, 32'h1234_5678, 1'b1, 4'hF);
        step();
        check("rst_hold_gone", {62'b0, ack, leaf_wen}, 64'h2);
        release_bus();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
